// File: rtl/frame_serializer_if.sv
// Symbol-in / serial-out bus of the frame serializer.
// The producer side drives symbols and mode; the serializer drives the serial stream and busy.
interface frame_serializer_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             mode;
    logic             out;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_valid, in_data, mode,
        input  out, out_valid, busy
    );

    modport slave (
        input  in_valid, in_data, mode,
        output out, out_valid, busy
    );
endinterface

// File: rtl/frame_serializer.sv
// Collects up to DEPTH symbols per frame, then emits them serially MSB first
// (arrival or reversed order) followed by a WIDTH-bit modular checksum.
module frame_serializer #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input logic               clk,
    input logic               rst,
    frame_serializer_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        CKSUM
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] checksum;
    logic             mode_r;
    logic [IW-1:0]    rd_ptr;
    logic [CW-1:0]    sym_left;
    logic [BW-1:0]    bit_idx;
    logic [WIDTH-1:0] cur_sym;

    logic start_frame;
    logic store_more;
    logic last_sym_bit;

    assign start_frame  = (state == IDLE) && bus.in_valid;
    assign store_more   = (state == LOAD) && bus.in_valid && (count < DEPTH_C);
    assign last_sym_bit = (bit_idx == '0) && (sym_left == CW'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        bus.out_valid = 1'b0;
        bus.out       = 1'b0;
        bus.busy      = 1'b0;
        cur_sym       = mem[rd_ptr];

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                bus.busy = 1'b1;
                if (!bus.in_valid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out       = cur_sym[bit_idx];
                if (last_sym_bit) begin
                    state_next = CKSUM;
                end
            end
            CKSUM: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out       = checksum[bit_idx];
                if (bit_idx == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: the symbol buffer has no reset; a frame only ever reads indices
    // it wrote itself, so stale contents can never reach the output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (start_frame) begin
                mem[0] <= bus.in_data;
            end else if (store_more) begin
                mem[count[IW-1:0]] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            checksum <= '0;
            mode_r   <= 1'b0;
            rd_ptr   <= '0;
            sym_left <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        count    <= CW'(1);
                        checksum <= bus.in_data;
                        mode_r   <= bus.mode;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        // Symbols beyond DEPTH are dropped and stay out of the checksum.
                        if (count < DEPTH_C) begin
                            count    <= count + CW'(1);
                            checksum <= checksum + bus.in_data;
                        end
                    end else begin
                        rd_ptr   <= mode_r ? IW'(count - CW'(1)) : '0;
                        sym_left <= count;
                        bit_idx  <= BIT_TOP;
                    end
                end
                SEND: begin
                    if (bit_idx == '0) begin
                        bit_idx  <= BIT_TOP;
                        sym_left <= sym_left - CW'(1);
                        rd_ptr   <= mode_r ? rd_ptr - IW'(1) : rd_ptr + IW'(1);
                    end else begin
                        bit_idx <= bit_idx - BW'(1);
                    end
                end
                CKSUM: begin
                    bit_idx <= bit_idx - BW'(1);
                end
                default: begin
                    bit_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer (WIDTH=3, DEPTH=8): ordering, overflow,
// single-symbol frames, reset abort, ignored input while sending, back-to-back frames.
module tb_frame_serializer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    frame_serializer_if #(.WIDTH(3)) bus ();

    frame_serializer #(
        .WIDTH(3),
        .DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one frame; mode is only correct on the first symbol, flipped afterwards.
    task automatic drive_frame(input int syms[$], input bit m);
        for (int i = 0; i < syms.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 3'(syms[i]);
            bus.mode     = (i == 0) ? m : !m;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        tick();
    endtask

    // Records the serial stream while out_valid is high, bounded by max_n bits.
    task automatic collect(input int max_n, input int inj_lo, input int inj_hi,
                           output logic [63:0] bits, output int n, output bit busy_ok);
        bits    = '0;
        n       = 0;
        busy_ok = 1'b1;
        while (bus.out_valid === 1'b1 && n < max_n) begin
            bits = {bits[62:0], bus.out};
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            bus.in_valid = (n >= inj_lo) && (n <= inj_hi);
            bus.in_data  = 3'd4;
            n++;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 3'd5;
        bus.mode     = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out !== 1'b0) begin
            errors++; $display("FAIL reset_out: got %b want 0", bus.out);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: busy=%b out_valid=%b want 0 0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_arrival_order();
        int syms[$];
        logic [63:0] bits;
        int n;
        bit busy_ok;
        syms = {5, 2, 7};
        drive_frame(syms, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL fwd_latency: out_valid=%b want 1", bus.out_valid);
        end
        collect(64, -1, -2, bits, n, busy_ok);
        checks++;
        if (n !== 12) begin
            errors++; $display("FAIL fwd_len: got %0d want 12", n);
        end
        checks++;
        if (bits[11:0] !== 12'b101_010_111_110) begin
            errors++; $display("FAIL fwd_bits: got %b want 101010111110", bits[11:0]);
        end
        checks++;
        if (!busy_ok || bus.busy !== 1'b0 || bus.out !== 1'b0) begin
            errors++;
            $display("FAIL fwd_tail: busy_ok=%b busy=%b out=%b want 1 0 0", busy_ok, bus.busy, bus.out);
        end
    endtask

    task automatic test_reverse_order();
        int syms[$];
        logic [63:0] bits;
        int n;
        bit busy_ok;
        syms = {5, 2, 7};
        drive_frame(syms, 1'b1);
        collect(64, -1, -2, bits, n, busy_ok);
        checks++;
        if (n !== 12) begin
            errors++; $display("FAIL rev_len: got %0d want 12", n);
        end
        checks++;
        if (bits[11:0] !== 12'b111_010_101_110) begin
            errors++; $display("FAIL rev_bits: got %b want 111010101110", bits[11:0]);
        end
    endtask

    task automatic test_overflow();
        int syms[$];
        logic [63:0] bits;
        int n;
        bit busy_ok;
        syms = {1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        drive_frame(syms, 1'b0);
        collect(64, -1, -2, bits, n, busy_ok);
        checks++;
        if (n !== 27) begin
            errors++; $display("FAIL ovf_len: got %0d want 27", n);
        end
        checks++;
        if (bits[26:0] !== 27'b001_010_011_100_101_110_111_000_100) begin
            errors++;
            $display("FAIL ovf_bits: got %b want 001010011100101110111000100", bits[26:0]);
        end
    endtask

    task automatic test_single();
        int syms[$];
        logic [63:0] bits;
        int n;
        bit busy_ok;
        syms = {0};
        drive_frame(syms, 1'b0);
        collect(64, -1, -2, bits, n, busy_ok);
        checks++;
        if (n !== 6 || bits[5:0] !== 6'b000_000) begin
            errors++; $display("FAIL single_bits: got %0d bits %b want 6 bits 000000", n, bits[5:0]);
        end
        checks++;
        if (!busy_ok || bus.busy !== 1'b0) begin
            errors++; $display("FAIL single_busy: busy_ok=%b busy=%b want 1 0", busy_ok, bus.busy);
        end
    endtask

    task automatic test_abort();
        int syms[$];
        logic [63:0] bits;
        int n;
        bit busy_ok;
        bit quiet;
        syms = {5, 2, 7};
        drive_frame(syms, 1'b0);
        collect(3, -1, -2, bits, n, busy_ok);
        checks++;
        if (n !== 3 || bits[2:0] !== 3'b101) begin
            errors++; $display("FAIL abort_prefix: got %0d bits %b want 3 bits 101", n, bits[2:0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: out_valid=%b out=%b busy=%b want 0 0 0",
                     bus.out_valid, bus.out, bus.busy);
        end
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.out !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL abort_quiet: got residual output want none");
        end
        syms = {3};
        drive_frame(syms, 1'b0);
        collect(64, -1, -2, bits, n, busy_ok);
        checks++;
        if (n !== 6 || bits[5:0] !== 6'b011_011) begin
            errors++; $display("FAIL abort_next: got %0d bits %b want 6 bits 011011", n, bits[5:0]);
        end
    endtask

    task automatic test_ignore_input();
        int syms[$];
        logic [63:0] bits;
        int n;
        bit busy_ok;
        bit quiet;
        syms = {5, 2, 7};
        drive_frame(syms, 1'b0);
        collect(64, 2, 5, bits, n, busy_ok);
        checks++;
        if (n !== 12 || bits[11:0] !== 12'b101_010_111_110) begin
            errors++;
            $display("FAIL ignore_bits: got %0d bits %b want 12 bits 101010111110", n, bits[11:0]);
        end
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
            tick();
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL ignore_extra: got an extra frame want idle");
        end
    endtask

    task automatic test_back_to_back();
        int syms[$];
        logic [63:0] bits;
        int n;
        bit busy_ok;
        syms = {7, 7, 7, 7};
        drive_frame(syms, 1'b0);
        collect(64, -1, -2, bits, n, busy_ok);
        checks++;
        if (n !== 15 || bits[14:0] !== 15'b111_111_111_111_100) begin
            errors++;
            $display("FAIL b2b_first: got %0d bits %b want 15 bits 111111111111100", n, bits[14:0]);
        end
        syms = {3, 6};
        drive_frame(syms, 1'b1);
        collect(64, -1, -2, bits, n, busy_ok);
        checks++;
        if (n !== 9 || bits[8:0] !== 9'b110_011_001) begin
            errors++; $display("FAIL b2b_second: got %0d bits %b want 9 bits 110011001", n, bits[8:0]);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mode     = 1'b0;
        test_reset();
        test_arrival_order();
        test_reverse_order();
        test_overflow();
        test_single();
        test_abort();
        test_ignore_input();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter WIDTH, default 3, bits per input symbol (WIDTH >= 1).
REQ-002 Parameter DEPTH, default 8, maximum symbols stored per frame (DEPTH >= 1).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 IN_VALID  input  1  high marks a valid symbol on INPUT in that cycle.
REQ-006 INPUT  input  WIDTH  symbol data, qualified by IN_VALID.
REQ-007 MODE  input  1  output order: 0 = arrival order, 1 = reversed; sampled only with a frame's first symbol.
REQ-008 OUT  output  1  serial output bit, qualified by OUT_VALID.
REQ-009 OUT_VALID  output  1  high while OUT carries a frame bit.
REQ-010 BUSY  output  1  high from a frame's first accepted symbol until its last output bit.

Function
REQ-011 States SHALL be IDLE, LOAD, SEND, CKSUM.
REQ-012 IDLE: IN_VALID=1 stores INPUT as symbol 0, latches MODE, sets count=1, and moves to LOAD.
REQ-013 LOAD, IN_VALID=1: stores the symbol at index count if count < DEPTH and increments count; symbols arriving with count = DEPTH are discarded without error.
REQ-014 LOAD, IN_VALID=0: ends the frame and moves to SEND; OUT_VALID SHALL be high in the cycle after the first IN_VALID=0 cycle (1-cycle latency).
REQ-015 SEND: outputs count*WIDTH bits, one per cycle, each symbol MSB first; symbol order is 0..count-1 (MODE=0) or count-1..0 (MODE=1).
REQ-016 CKSUM: follows SEND with no gap and outputs WIDTH bits MSB first of the checksum = sum of stored symbols mod 2^WIDTH; discarded symbols are excluded; MODE does not affect the checksum.
REQ-017 OUT_VALID SHALL be high for exactly (count+1)*WIDTH contiguous cycles per frame.
REQ-018 OUT SHALL be 0 whenever OUT_VALID=0.
REQ-019 After the last checksum bit the FSM returns to IDLE; OUT_VALID falls the next cycle.
REQ-020 IN_VALID in SEND or CKSUM is ignored, and no symbol is stored.
REQ-021 A new frame's first symbol MAY arrive in the first cycle with OUT_VALID=0 after a frame.
REQ-022 The checksum accumulator SHALL be WIDTH bits and wrap silently; the symbol counter SHALL hold 0..DEPTH without wrap.
REQ-023 A single-symbol frame (count=1) is legal and produces 2*WIDTH output bits.

Reset
REQ-024 RST=1 at a rising edge SHALL force IDLE, count=0, checksum=0, OUT=0, OUT_VALID=0, BUSY=0 from that edge on.
REQ-025 RST SHALL take priority over IN_VALID in the same cycle; that symbol is not stored.
REQ-026 RST during LOAD, SEND or CKSUM SHALL abort the frame; no remaining bits are emitted.
REQ-027 Buffer contents need no reset; after reset, stale data SHALL never reach OUT.

Verification (WIDTH=3, DEPTH=8)
REQ-028 Symbols 5,2,7 with MODE=0, then IN_VALID=0 -> OUT = 101 010 111 110 (checksum 14 mod 8 = 6); OUT_VALID high for 12 cycles starting one cycle after IN_VALID falls.
REQ-029 The same frame with MODE=1 -> OUT = 111 010 101 110.
REQ-030 Ten symbols 1,2,3,4,5,6,7,0,1,2 with MODE=0 -> only the first eight are sent (001..111,000), checksum 28 mod 8 = 4 (100); OUT_VALID high for 27 cycles.
REQ-031 Single symbol 0 -> OUT = 000 000; OUT_VALID high for 6 cycles; BUSY falls with OUT_VALID.
REQ-032 RST=1 for one cycle during the 4th output bit of REQ-028 -> OUT_VALID=0 and OUT=0 from the next cycle; a new frame 3 then gives 011 011.
REQ-033 IN_VALID=1 with INPUT=4 during SEND of REQ-028 -> output identical to REQ-028, and no extra frame follows.
